native_axi_master_bridge: RTL and testbench

NATIVE_AXI_MASTER_BRIDGE -- requirements
Module: native_axi_master_bridge

---
 rtl/native_axi_master_bridge_pkg.sv | 68 ++++++
 rtl/native_axi_master_bridge_if.sv | 36 +++
 rtl/native_axi_master_bridge_timeout_ctr.sv | 34 +++
 rtl/native_axi_master_bridge.sv | 174 +++++++++++++++++
 tb/tb_native_axi_master_bridge.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/native_axi_master_bridge_pkg.sv
// Shared types and constants for the native-to-AXI4-lite master bridge.
//   state_t        : bridge FSM states
//   RESP_*         : AXI response encodings
//   bridge_regs_t  : every registered output of the bridge, kept in one record
//   resp_is_err()  : SLVERR/DECERR detection
//   abort_regs()   : output image used when a phase times out
package axi_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  localparam logic [2:0] PROT_DATA  = 3'b000;
  localparam logic [2:0] PROT_INSTR = 3'b100;

  typedef struct packed {
    logic        arvalid;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rready;
    logic        awvalid;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bready;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_err;
  } bridge_regs_t;

  // Upper response bit marks both SLVERR and DECERR as errors.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

  // Drops every AXI valid/ready and reports a failed completion.
  // Read data is only replaced for reads; writes keep the previous value.
  function automatic bridge_regs_t abort_regs(input bridge_regs_t cur,
                                              input logic         is_read,
                                              input logic [31:0]  err_rdata);
    bridge_regs_t n;
    n           = cur;
    n.arvalid   = 1'b0;
    n.rready    = 1'b0;
    n.awvalid   = 1'b0;
    n.wvalid    = 1'b0;
    n.bready    = 1'b0;
    n.mem_ready = 1'b1;
    n.mem_err   = 1'b1;
    if (is_read) n.mem_rdata = err_rdata;
    return n;
  endfunction

endpackage

// File: rtl/native_axi_master_bridge_if.sv
// AXI4-lite bus bundle, all five channels, 32-bit address/data.
//   master : initiator view (drives valids on AW/W/AR, readies on B/R)
//   slave  : target view
interface axi_interf;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/native_axi_master_bridge_timeout_ctr.sv
// Per-phase wait counter for the bridge.
//   clk, resetn : clock, async active-low reset
//   clear       : restart from zero (state entry)
//   enable      : count this cycle (waiting on a handshake)
//   expired     : counter sits at TIMEOUT_CYCLES-1 while enabled
module bridge_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  // Holds at LAST rather than wrapping; the FSM leaves the phase on expiry anyway.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != LAST)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign expired = enable && (r_count == LAST);

endmodule

// File: rtl/native_axi_master_bridge.sv
// Native memory-port to AXI4-lite master bridge, one outstanding transaction.
//   clk, resetn         : clock, async active-low reset
//   mem_valid/instr     : request strobe, instruction-fetch qualifier
//   mem_addr/wdata/wstrb: request fields, wstrb==0 selects a read
//   mem_ready           : one-cycle completion pulse
//   mem_rdata, mem_err  : result, valid with mem_ready
//   axi                 : AXI4-lite initiator port
//
// state   | meaning
// IDLE    | waiting for mem_valid
// RD_ADDR | arvalid up, waiting for arready
// RD_DATA | rready up, waiting for rvalid
// WR_REQ  | awvalid/wvalid up, each dropped on its own handshake
// WR_RESP | bready up, waiting for bvalid
// DONE    | mem_ready pulse cycle, requests not sampled
module native_axi_master_bridge
  import axi_bridge_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             mem_valid,
  input  logic             mem_instr,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wstrb,
  output logic             mem_ready,
  output logic [31:0]      mem_rdata,
  output logic             mem_err,
  axi_interf.master        axi
);

  state_t       r_state;
  state_t       w_state_nxt;
  bridge_regs_t r_regs;
  bridge_regs_t w_regs_nxt;

  logic w_ar_hs;
  logic w_r_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_wait_state;
  logic w_tmo_clear;
  logic w_tmo_expired;

  assign w_ar_hs = r_regs.arvalid && axi.arready;
  assign w_r_hs  = r_regs.rready  && axi.rvalid;
  assign w_aw_hs = r_regs.awvalid && axi.awready;
  assign w_w_hs  = r_regs.wvalid  && axi.wready;
  assign w_b_hs  = r_regs.bready  && axi.bvalid;

  assign w_wait_state = (r_state == RD_ADDR) || (r_state == RD_DATA) ||
                        (r_state == WR_REQ)  || (r_state == WR_RESP);
  // Any state change restarts the phase budget.
  assign w_tmo_clear  = (w_state_nxt != r_state);

  bridge_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (w_tmo_clear),
    .enable  (w_wait_state),
    .expired (w_tmo_expired)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_regs  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_regs  <= w_regs_nxt;
    end
  end

  // Handshakes are tested before expiry so a late handshake still completes.
  always_comb begin
    w_state_nxt = r_state;
    w_regs_nxt  = r_regs;
    case (r_state)
      IDLE: begin
        if (mem_valid) begin
          if (mem_wstrb == 4'h0) begin
            w_regs_nxt.arvalid = 1'b1;
            w_regs_nxt.araddr  = mem_addr;
            w_regs_nxt.arprot  = mem_instr ? PROT_INSTR : PROT_DATA;
            w_state_nxt        = RD_ADDR;
          end else begin
            w_regs_nxt.awvalid = 1'b1;
            w_regs_nxt.wvalid  = 1'b1;
            w_regs_nxt.awaddr  = mem_addr;
            w_regs_nxt.awprot  = PROT_DATA;
            w_regs_nxt.wdata   = mem_wdata;
            w_regs_nxt.wstrb   = mem_wstrb;
            w_state_nxt        = WR_REQ;
          end
        end
      end
      RD_ADDR: begin
        if (w_ar_hs) begin
          w_regs_nxt.arvalid = 1'b0;
          w_regs_nxt.rready  = 1'b1;
          w_state_nxt        = RD_DATA;
        end else if (w_tmo_expired) begin
          w_regs_nxt  = abort_regs(r_regs, 1'b1, ERR_RDATA);
          w_state_nxt = DONE;
        end
      end
      RD_DATA: begin
        if (w_r_hs) begin
          w_regs_nxt.rready    = 1'b0;
          w_regs_nxt.mem_rdata = axi.rdata;
          w_regs_nxt.mem_err   = resp_is_err(axi.rresp);
          w_regs_nxt.mem_ready = 1'b1;
          w_state_nxt          = DONE;
        end else if (w_tmo_expired) begin
          w_regs_nxt  = abort_regs(r_regs, 1'b1, ERR_RDATA);
          w_state_nxt = DONE;
        end
      end
      WR_REQ: begin
        if (w_aw_hs) w_regs_nxt.awvalid = 1'b0;
        if (w_w_hs)  w_regs_nxt.wvalid  = 1'b0;
        if (!w_regs_nxt.awvalid && !w_regs_nxt.wvalid) begin
          w_regs_nxt.bready = 1'b1;
          w_state_nxt       = WR_RESP;
        end else if (w_tmo_expired) begin
          w_regs_nxt  = abort_regs(r_regs, 1'b0, ERR_RDATA);
          w_state_nxt = DONE;
        end
      end
      WR_RESP: begin
        if (w_b_hs) begin
          w_regs_nxt.bready    = 1'b0;
          w_regs_nxt.mem_err   = resp_is_err(axi.bresp);
          w_regs_nxt.mem_ready = 1'b1;
          w_state_nxt          = DONE;
        end else if (w_tmo_expired) begin
          w_regs_nxt  = abort_regs(r_regs, 1'b0, ERR_RDATA);
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_regs_nxt.mem_ready = 1'b0;
        w_regs_nxt.mem_err   = 1'b0;
        w_state_nxt          = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign axi.arvalid = r_regs.arvalid;
  assign axi.araddr  = r_regs.araddr;
  assign axi.arprot  = r_regs.arprot;
  assign axi.rready  = r_regs.rready;
  assign axi.awvalid = r_regs.awvalid;
  assign axi.awaddr  = r_regs.awaddr;
  assign axi.awprot  = r_regs.awprot;
  assign axi.wvalid  = r_regs.wvalid;
  assign axi.wdata   = r_regs.wdata;
  assign axi.wstrb   = r_regs.wstrb;
  assign axi.bready  = r_regs.bready;

  assign mem_ready = r_regs.mem_ready;
  assign mem_rdata = r_regs.mem_rdata;
  assign mem_err   = r_regs.mem_err;

endmodule

// File: tb/tb_native_axi_master_bridge.sv
module tb_native_axi_master_bridge;
  import axi_bridge_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready, mem_err;
  logic [31:0] mem_rdata;

  axi_interf axi_if();

  native_axi_master_bridge #(
    .TIMEOUT_CYCLES (TO),
    .ERR_RDATA      (32'hDEAD_BEEF)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .mem_err   (mem_err),
    .axi       (axi_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // slave behaviour knobs
  int          ar_delay = 0, aw_delay = 0, w_delay = 0;
  bit          b_block = 1'b0;
  logic [31:0] sl_rdata = '0;
  logic [1:0]  sl_rresp = RESP_OKAY, sl_bresp = RESP_OKAY;

  // slave observations
  int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
  logic [31:0] cap_araddr = '0, cap_awaddr = '0, cap_wdata = '0;
  logic [2:0]  cap_arprot = '0;
  logic [3:0]  cap_wstrb = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // AXI4-lite slave: samples handshakes on the edge, drives #1 later.
  initial begin
    int ar_wait, aw_wait, w_wait;
    bit aw_got, w_got, r_pend, b_pend;
    ar_wait = 0; aw_wait = 0; w_wait = 0;
    aw_got = 0; w_got = 0; r_pend = 0; b_pend = 0;
    axi_if.arready = 1'b0; axi_if.awready = 1'b0; axi_if.wready = 1'b0;
    axi_if.rvalid = 1'b0; axi_if.bvalid = 1'b0;
    axi_if.rdata = '0; axi_if.rresp = '0; axi_if.bresp = '0;
    forever begin
      @(posedge clk);
      if (!resetn) begin
        ar_wait = 0; aw_wait = 0; w_wait = 0;
        aw_got = 0; w_got = 0; r_pend = 0; b_pend = 0;
      end else begin
        if (axi_if.arvalid && axi_if.arready) begin
          ar_cnt++; cap_araddr = axi_if.araddr; cap_arprot = axi_if.arprot;
          r_pend = 1; ar_wait = 0;
        end else if (axi_if.arvalid) ar_wait++;
        else ar_wait = 0;
        if (axi_if.rvalid && axi_if.rready) r_pend = 0;
        if (axi_if.awvalid && axi_if.awready) begin
          aw_cnt++; cap_awaddr = axi_if.awaddr; aw_got = 1; aw_wait = 0;
        end else if (axi_if.awvalid) aw_wait++;
        else aw_wait = 0;
        if (axi_if.wvalid && axi_if.wready) begin
          w_cnt++; cap_wdata = axi_if.wdata; cap_wstrb = axi_if.wstrb; w_got = 1; w_wait = 0;
        end else if (axi_if.wvalid) w_wait++;
        else w_wait = 0;
        if (axi_if.bvalid && axi_if.bready) b_pend = 0;
        if (aw_got && w_got) begin b_pend = 1; aw_got = 0; w_got = 0; end
      end
      #1;
      axi_if.arready = (ar_delay == 0) || (ar_wait >= ar_delay);
      axi_if.awready = (aw_delay == 0) || (aw_wait >= aw_delay);
      axi_if.wready  = (w_delay == 0)  || (w_wait >= w_delay);
      axi_if.rvalid  = r_pend;
      axi_if.rdata   = sl_rdata;
      axi_if.rresp   = sl_rresp;
      axi_if.bvalid  = b_pend && !b_block;
      axi_if.bresp   = sl_bresp;
    end
  end

  task automatic push_exp(input logic [31:0] rdata, input logic err, input int lat);
    exp_t e;
    e.rdata = rdata; e.err = err; e.lat = lat;
    sb_q.push_back(e);
  endtask

  // Called #1 after an edge; cyc is the cycle index relative to the sampling edge.
  task automatic wait_ready(inout int cyc, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      if (mem_ready === 1'b1) ok = 1'b1;
      else begin @(posedge clk); #1; cyc++; end
    end
  endtask

  task automatic pop_check(input string tag, input int cyc, input bit ok);
    exp_t e;
    if (!ok) begin
      chk({tag, "_ready_seen"}, 32'(ok), 32'd1);
      if (sb_q.size() > 0) e = sb_q.pop_front();
    end else if (sb_q.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_lat"},   32'(cyc), 32'(e.lat));
      chk({tag, "_rdata"}, mem_rdata, e.rdata);
      chk({tag, "_err"},   32'(mem_err), 32'(e.err));
    end
  endtask

  // One request, inputs scrambled right after sampling (must be ignored).
  task automatic do_req(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic instr,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int cyc;
    bit ok;
    push_exp(exp_rdata, exp_err, exp_lat);
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb; mem_instr = instr;
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_addr = ~addr; mem_wdata = ~wdata; mem_wstrb = ~wstrb; mem_instr = ~instr;
    cyc = 1;
    wait_ready(cyc, ok);
    pop_check(tag, cyc, ok);
    if (ok) begin
      @(posedge clk); #1;
      chk({tag, "_pulse"}, 32'(mem_ready), 32'd0);
      chk({tag, "_err_clr"}, 32'(mem_err), 32'd0);
    end
  endtask

  initial begin
    int base, cyc;
    bit ok;
    mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arvalid", 32'(axi_if.arvalid), 32'd0);
    chk("rst_awvalid", 32'(axi_if.awvalid), 32'd0);
    chk("rst_wvalid",  32'(axi_if.wvalid),  32'd0);
    chk("rst_rready",  32'(axi_if.rready),  32'd0);
    chk("rst_bready",  32'(axi_if.bready),  32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    chk("rst_araddr", axi_if.araddr, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // zero-wait read
    sl_rdata = 32'h0000_0001; sl_rresp = RESP_OKAY;
    do_req("rd_okay", 32'h0001_8000, 32'h0, 4'h0, 1'b0, 32'h0000_0001, 1'b0, 3);
    chk("rd_okay_araddr", cap_araddr, 32'h0001_8000);
    chk("rd_okay_arprot", 32'(cap_arprot), 32'd0);

    // instruction fetch protection
    sl_rdata = 32'hCAFE_0002;
    do_req("rd_instr", 32'h0000_0400, 32'h0, 4'h0, 1'b1, 32'hCAFE_0002, 1'b0, 3);
    chk("rd_instr_arprot", 32'(cap_arprot), 32'h4);

    // write, W ready three cycles after AW accepted
    base = aw_cnt; cyc = w_cnt;
    w_delay = 3;
    do_req("wr_aw_first", 32'h0001_8008, 32'h0000_0041, 4'hF, 1'b0, 32'hCAFE_0002, 1'b0, 6);
    w_delay = 0;
    chk("wr_aw_count", 32'(aw_cnt - base), 32'd1);
    chk("wr_w_count", 32'(w_cnt - cyc), 32'd1);
    chk("wr_awaddr", cap_awaddr, 32'h0001_8008);
    chk("wr_wdata", cap_wdata, 32'h0000_0041);
    chk("wr_wstrb", 32'(cap_wstrb), 32'hF);

    // write, W accepted before AW
    aw_delay = 2;
    do_req("wr_w_first", 32'h0001_8010, 32'h0000_0055, 4'h3, 1'b0, 32'hCAFE_0002, 1'b0, 5);
    aw_delay = 0;
    chk("wr_w_first_wstrb", 32'(cap_wstrb), 32'h3);

    // same-cycle AW/W, DECERR response
    sl_bresp = RESP_DECERR;
    do_req("wr_decerr", 32'h0001_8014, 32'h0000_0066, 4'h1, 1'b0, 32'hCAFE_0002, 1'b1, 3);
    sl_bresp = RESP_OKAY;

    // SLVERR read then a normal one
    sl_rdata = 32'h1234_5678; sl_rresp = RESP_SLVERR;
    do_req("rd_slverr", 32'h0001_8018, 32'h0, 4'h0, 1'b0, 32'h1234_5678, 1'b1, 3);
    sl_rresp = RESP_OKAY; sl_rdata = 32'h0000_0077;
    do_req("rd_after_err", 32'h0001_801C, 32'h0, 4'h0, 1'b0, 32'h0000_0077, 1'b0, 3);

    // arready never comes: abort after the phase budget
    ar_delay = 1000; base = ar_cnt;
    do_req("rd_timeout", 32'h0002_0000, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, 1'b1, TO + 1);
    chk("rd_timeout_arvalid", 32'(axi_if.arvalid), 32'd0);
    chk("rd_timeout_no_hs", 32'(ar_cnt - base), 32'd0);
    ar_delay = 0;
    sl_rdata = 32'h0000_0088;
    do_req("rd_after_to", 32'h0001_8020, 32'h0, 4'h0, 1'b0, 32'h0000_0088, 1'b0, 3);

    // reset while waiting for B
    b_block = 1'b1;
    mem_valid = 1'b1; mem_addr = 32'h0001_8024; mem_wdata = 32'h0000_A5A5; mem_wstrb = 4'hF;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_bready_pre", 32'(axi_if.bready), 32'd1);
    resetn = 1'b0;
    #1;
    chk("rst_mid_bready", 32'(axi_if.bready), 32'd0);
    chk("rst_mid_awaddr", axi_if.awaddr, 32'd0);
    chk("rst_mid_wdata", axi_if.wdata, 32'd0);
    chk("rst_mid_wstrb", 32'(axi_if.wstrb), 32'd0);
    chk("rst_mid_rdata", mem_rdata, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_mid_no_ready", 32'(mem_ready), 32'd0);
    end
    resetn = 1'b1; b_block = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_no_ready_after", 32'(mem_ready), 32'd0);
    sl_rdata = 32'h0000_0099;
    do_req("rd_after_rst", 32'h0001_8000, 32'h0, 4'h0, 1'b0, 32'h0000_0099, 1'b0, 3);

    // back-to-back reads with mem_valid held high
    sl_rdata = 32'h0000_0BB0; base = ar_cnt;
    push_exp(32'h0000_0BB0, 1'b0, 3);
    push_exp(32'h0000_0BB0, 1'b0, 3);
    mem_valid = 1'b1; mem_addr = 32'h0001_8004; mem_wstrb = 4'h0; mem_instr = 1'b0;
    @(posedge clk); #1;
    cyc = 1;
    wait_ready(cyc, ok);
    pop_check("b2b_first", cyc, ok);
    @(posedge clk); #1;
    chk("b2b_gap_ready", 32'(mem_ready), 32'd0);
    chk("b2b_gap_arvalid", 32'(axi_if.arvalid), 32'd0);
    chk("b2b_gap_count", 32'(ar_cnt - base), 32'd1);
    @(posedge clk); #1;
    chk("b2b_second_arvalid", 32'(axi_if.arvalid), 32'd1);
    cyc = 1;
    wait_ready(cyc, ok);
    pop_check("b2b_second", cyc, ok);
    mem_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_ar_total", 32'(ar_cnt - base), 32'd2);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
